program_counter: RTL and testbench

Parametrised successor to the single-step instruction-address counter. It holds the CPU's current instruction address and advances it by sequential increment, absolute jump, PC-relative branch, call or return. A small internal return-address stack (RAS) supports call and return. Sits between the control unit (which issues op/en) and instruction memory (which consumes pc).

---
 rtl/program_counter_pkg.sv | 21 ++
 rtl/program_counter_if.sv | 27 ++
 rtl/program_counter_ras.sv | 52 +++++
 rtl/program_counter.sv | 104 ++++++++++
 tb/tb_program_counter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/program_counter_pkg.sv
// Shared types for the program counter: op encoding and a wrapped-add helper.
package pc_pkg;

    localparam int MAX_AW = 16;

    typedef enum logic [2:0] {
        NEXT   = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4,
        HOLD   = 3'd5
    } pc_op_t;

    // Callers truncate the result to their own width, which gives modulo-2^AW wrap.
    function automatic logic [MAX_AW-1:0] add_wrap(input logic [MAX_AW-1:0] a,
                                                   input logic [MAX_AW-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Control-unit side bundle of the program counter: op strobe in, pc and status out.
interface program_counter_if #(
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic [AW-1:0] offset;
    logic          clr_err;
    logic [AW-1:0] pc;
    logic          ras_empty;
    logic          ras_full;
    logic          err_ovf;
    logic          err_unf;
    logic [CW-1:0] retire_cnt;

    modport master (
        output en, op, target, offset, clr_err,
        input  pc, ras_empty, ras_full, err_ovf, err_unf, retire_cnt
    );

    modport slave (
        input  en, op, target, offset, clr_err,
        output pc, ras_empty, ras_full, err_ovf, err_unf, retire_cnt
    );
endinterface

// File: rtl/program_counter_ras.sv
// Return-address stack: LIFO of RAS_DEPTH entries, registered empty/full flags.
module pc_ras #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int IW = $clog2(RAS_DEPTH);
    localparam int PW = IW + 1;

    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, ptr_m1;
    logic          empty_q, full_q;

    assign ptr_m1 = ptr_q - PW'(1);
    assign top    = mem[ptr_m1[IW-1:0]];
    assign empty  = empty_q;
    assign full   = full_q;

    always_comb begin
        ptr_d = ptr_q;
        if (push)
            ptr_d = ptr_q + PW'(1);
        else if (pop)
            ptr_d = ptr_m1;
    end

    // Flags are derived from the next pointer so they match ptr_q in every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            empty_q <= (ptr_d == '0);
            full_q  <= (ptr_d == PW'(RAS_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_q[IW-1:0]] <= push_data;
    end
endmodule

// File: rtl/program_counter.sv
// Instruction-address counter with NEXT/JUMP/BRANCH/CALL/RET/HOLD and a return stack.
// Define PC_RETIRE_CNT_EN to build the retired-op counter; otherwise retire_cnt is 0.
module program_counter
    import pc_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            CW        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    program_counter_if.slave  bus
);
    logic [AW-1:0] pc_q, pc_d, pc_inc, pc_br;
    logic          err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
    logic          ras_push, ras_pop, ras_empty, ras_full;
    logic          ovf_evt, unf_evt;
    logic [AW-1:0] ras_top;

    assign pc_inc = AW'(add_wrap(MAX_AW'(pc_q), MAX_AW'(1)));
    assign pc_br  = AW'(add_wrap(MAX_AW'(pc_q), MAX_AW'(bus.offset)));

    always_comb begin
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                NEXT:   pc_d = pc_inc;
                JUMP:   pc_d = bus.target;
                BRANCH: pc_d = pc_br;
                CALL: begin
                    pc_d     = bus.target;
                    ras_push = !ras_full;
                    ovf_evt  = ras_full;
                end
                RET: begin
                    if (ras_empty) begin
                        pc_d    = pc_inc;
                        unf_evt = 1'b1;
                    end else begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    // A fresh error event outranks a clear issued in the same cycle.
    assign err_ovf_d = ovf_evt ? 1'b1 : (bus.clr_err ? 1'b0 : err_ovf_q);
    assign err_unf_d = unf_evt ? 1'b1 : (bus.clr_err ? 1'b0 : err_unf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

`ifdef PC_RETIRE_CNT_EN
    logic [CW-1:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_q <= '0;
        else if (bus.en)
            retire_q <= retire_q + CW'(1);
    end

    assign bus.retire_cnt = retire_q;
`else
    assign bus.retire_cnt = {CW{1'b0}};
`endif

    assign bus.pc        = pc_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_unf   = err_unf_q;
endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (AW=8, RAS_DEPTH=4, RESET_VEC=0).
module tb_program_counter;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_retire = 0;

    program_counter_if #(.AW(8), .CW(16)) bus ();

    program_counter #(
        .AW        (8),
        .RAS_DEPTH (4),
        .RESET_VEC (8'h00),
        .CW        (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one op on the falling edge, sample #1 after the rising edge.
    task automatic apply(input logic en, input pc_op_t op, input logic [7:0] tgt,
                         input logic [7:0] off, input logic clr);
        @(negedge clk);
        bus.en      = en;
        bus.op      = op;
        bus.target  = tgt;
        bus.offset  = off;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        if (en) exp_retire++;
        bus.en      = 1'b0;
        bus.clr_err = 1'b0;
        $display("op=%0d en=%0b tgt=%02h off=%02h clr=%0b -> pc=%02h empty=%0b full=%0b ovf=%0b unf=%0b",
                 op, en, tgt, off, clr, bus.pc, bus.ras_empty, bus.ras_full, bus.err_ovf, bus.err_unf);
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.op = HOLD; bus.target = '0; bus.offset = '0; bus.clr_err = 1'b0;
        #12;
        n_vec++;
        if (bus.pc !== 8'h00 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 ||
            bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init pc=%02h e=%0b f=%0b ovf=%0b unf=%0b required pc=00 e=1 f=0 ovf=0 unf=0",
                     bus.pc, bus.ras_empty, bus.ras_full, bus.err_ovf, bus.err_unf);
        end
        @(negedge clk); rst_n = 1'b1;
        apply(1'b1, CALL, 8'h10, 8'h00, 1'b0);
        apply(1'b1, CALL, 8'h37, 8'h00, 1'b0);
        apply(1'b1, RET,  8'h00, 8'h00, 1'b0);
        apply(1'b1, CALL, 8'h37, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h37 || bus.ras_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_setup pc=%02h e=%0b required pc=37 e=0", bus.pc, bus.ras_empty);
        end
        // Assert reset between edges; outputs must clear without a clock.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        exp_retire = 0;
        n_vec++;
        if (bus.pc !== 8'h00 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 ||
            bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async pc=%02h e=%0b f=%0b ovf=%0b unf=%0b required pc=00 e=1 f=0 ovf=0 unf=0",
                     bus.pc, bus.ras_empty, bus.ras_full, bus.err_ovf, bus.err_unf);
        end
        $display("async reset -> pc=%02h empty=%0b", bus.pc, bus.ras_empty);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        apply(1'b1, JUMP, 8'hFE, 8'h00, 1'b0);
        apply(1'b1, NEXT, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'hFF) begin n_bad++; $display("FAIL next_ff pc=%02h required FF", bus.pc); end
        apply(1'b1, NEXT, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h00) begin n_bad++; $display("FAIL next_wrap pc=%02h required 00", bus.pc); end
        apply(1'b0, JUMP, 8'h55, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h00) begin n_bad++; $display("FAIL en_low_hold pc=%02h required 00", bus.pc); end
        apply(1'b1, 3'd7 == 3'd7 ? pc_op_t'(3'd7) : HOLD, 8'h55, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h00) begin n_bad++; $display("FAIL undef_op pc=%02h required 00", bus.pc); end
    endtask

    task automatic test_branch();
        apply(1'b1, JUMP,   8'h10, 8'h00, 1'b0);
        apply(1'b1, BRANCH, 8'h00, 8'hFC, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h0C) begin n_bad++; $display("FAIL branch_neg4 pc=%02h required 0C", bus.pc); end
        apply(1'b1, JUMP,   8'h05, 8'h00, 1'b0);
        apply(1'b1, BRANCH, 8'h00, 8'hF0, 1'b0);
        n_vec++;
        if (bus.pc !== 8'hF5) begin n_bad++; $display("FAIL branch_wrap pc=%02h required F5", bus.pc); end
        apply(1'b1, BRANCH, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'hF5) begin n_bad++; $display("FAIL branch_zero pc=%02h required F5", bus.pc); end
        apply(1'b1, BRANCH, 8'h00, 8'h0D, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h02) begin n_bad++; $display("FAIL branch_pos pc=%02h required 02", bus.pc); end
    endtask

    task automatic test_nested_call();
        logic [7:0] exp_pc [4] = '{8'h80, 8'h90, 8'h81, 8'h21};
        pc_op_t     ops    [4] = '{CALL, CALL, RET, RET};
        logic [7:0] tgts   [4] = '{8'h80, 8'h90, 8'h00, 8'h00};
        apply(1'b1, JUMP, 8'h20, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, ops[i], tgts[i], 8'h00, 1'b0);
            n_vec++;
            if (bus.pc !== exp_pc[i]) begin
                n_bad++;
                $display("FAIL nested_%0d pc=%02h required %02h", i, bus.pc, exp_pc[i]);
            end
        end
        n_vec++;
        if (bus.ras_empty !== 1'b1 || bus.err_unf !== 1'b0) begin
            n_bad++;
            $display("FAIL nested_empty e=%0b unf=%0b required e=1 unf=0", bus.ras_empty, bus.err_unf);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] tgts [4] = '{8'h50, 8'h60, 8'h70, 8'h80};
        logic [7:0] rets [4] = '{8'h71, 8'h61, 8'h51, 8'h41};
        apply(1'b1, JUMP, 8'h40, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b1, CALL, tgts[i], 8'h00, 1'b0);
        n_vec++;
        if (bus.ras_full !== 1'b1 || bus.err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ras_full f=%0b ovf=%0b required f=1 ovf=0", bus.ras_full, bus.err_ovf);
        end
        apply(1'b1, CALL, 8'hA0, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'hA0 || bus.ras_full !== 1'b1 || bus.err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL call_ovf pc=%02h f=%0b ovf=%0b required pc=A0 f=1 ovf=1",
                     bus.pc, bus.ras_full, bus.err_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, RET, 8'h00, 8'h00, 1'b0);
            n_vec++;
            if (bus.pc !== rets[i]) begin
                n_bad++;
                $display("FAIL ret_%0d pc=%02h required %02h", i, bus.pc, rets[i]);
            end
        end
        apply(1'b1, RET, 8'h00, 8'h00, 1'b0);
        n_vec++;
        if (bus.pc !== 8'h42 || bus.err_unf !== 1'b1 || bus.err_ovf !== 1'b1 || bus.ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL ret_unf pc=%02h unf=%0b ovf=%0b e=%0b required pc=42 unf=1 ovf=1 e=1",
                     bus.pc, bus.err_unf, bus.err_ovf, bus.ras_empty);
        end
        // Clear coinciding with a new underflow: underflow stays set, overflow clears.
        apply(1'b1, RET, 8'h00, 8'h00, 1'b1);
        n_vec++;
        if (bus.pc !== 8'h43 || bus.err_unf !== 1'b1 || bus.err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_vs_evt pc=%02h unf=%0b ovf=%0b required pc=43 unf=1 ovf=0",
                     bus.pc, bus.err_unf, bus.err_ovf);
        end
        apply(1'b1, HOLD, 8'h00, 8'h00, 1'b1);
        n_vec++;
        if (bus.pc !== 8'h43 || bus.err_unf !== 1'b0 || bus.err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_err pc=%02h unf=%0b ovf=%0b required pc=43 unf=0 ovf=0",
                     bus.pc, bus.err_unf, bus.err_ovf);
        end
    endtask

    task automatic test_retire();
        pc_op_t ops [10] = '{NEXT, JUMP, BRANCH, CALL, RET, HOLD, NEXT, CALL, RET, HOLD};
        int base;
        base = exp_retire;
        for (int i = 0; i < 10; i++) apply(1'b1, ops[i], 8'h30, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, NEXT, 8'h00, 8'h00, 1'b0);
        n_vec++;
`ifdef PC_RETIRE_CNT_EN
        if (exp_retire - base != 10 || bus.retire_cnt !== 16'(exp_retire)) begin
            n_bad++;
            $display("FAIL retire_cnt got=%0d required=%0d", bus.retire_cnt, exp_retire);
        end
`else
        if (bus.retire_cnt !== 16'h0000 || exp_retire - base != 10) begin
            n_bad++;
            $display("FAIL retire_cnt got=%0d required=0", bus.retire_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_branch();
        test_nested_call();
        test_overflow();
        test_retire();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
